// File: rtl/bcd_digit_collector.sv
// Collects NDIG BCD digits into a packed word; first digit lands in the top nibble.
// Latency: word or error report is valid 1 cycle after the last/bad digit is accepted.
// Backpressure: in_ready drops while a word or error is held; held until out_ready.
// Optional: define BCD_COLLECT_BIN_EN to add the out_bin running binary value.
module bcd_digit_collector #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_digit,
    input  logic              in_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [4*NDIG-1:0] out_value,
    output logic              out_valid,
    output logic              out_err,
    input  logic              out_ready,
`ifdef BCD_COLLECT_BIN_EN
    output logic [13:0]       out_bin,
`endif
    output logic [2:0]        digit_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t state;

    logic              accept;
    logic              bad_digit;
    logic              last_digit;
    logic [4*NDIG-1:0] shifted;

    // A single-digit word has nothing to shift; the new digit is the whole word.
    generate
        if (NDIG == 1) begin : g_one
            assign shifted = in_digit;
        end else begin : g_multi
            assign shifted = {out_value[4*NDIG-5:0], in_digit};
        end
    endgenerate

    assign in_ready   = (state == IDLE) || (state == COLLECT);
    assign accept     = in_valid && in_ready;
    assign bad_digit  = in_err || (in_digit > 4'd9);
    assign last_digit = (digit_cnt == 3'(NDIG - 1));

    // Collector state machine; rst and clear both return to an empty IDLE word.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= IDLE;
            out_value <= '0;
            digit_cnt <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (bad_digit) begin
                            // Partial word is kept for inspection alongside the error.
                            state     <= ERR;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                        end else begin
                            out_value <= shifted;
                            digit_cnt <= digit_cnt + 3'd1;
                            if (last_digit) begin
                                state     <= FULL;
                                out_valid <= 1'b1;
                                out_err   <= 1'b0;
                            end else begin
                                state <= COLLECT;
                            end
                        end
                    end
                end
                FULL, ERR: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_value <= '0;
                        digit_cnt <= '0;
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCD_COLLECT_BIN_EN
    // Running binary value of the good digits, cleared whenever the word is emptied.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            out_bin <= '0;
        end else if ((state == FULL || state == ERR) && out_ready) begin
            out_bin <= '0;
        end else if (accept && !bad_digit) begin
            out_bin <= 14'(out_bin * 14'd10 + {10'd0, in_digit});
        end
    end
`endif

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Directed-vector bench for bcd_digit_collector with NDIG=4.
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
// Define BCD_COLLECT_BIN_EN to also exercise out_bin.
module tb_bcd_digit_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_digit;
    logic        in_err;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic [15:0] out_value;
    logic        out_valid;
    logic        out_err;
    logic        out_ready;
    logic [2:0]  digit_cnt;
`ifdef BCD_COLLECT_BIN_EN
    logic [13:0] out_bin;
`endif

    int checks_run  = 0;
    int checks_fail = 0;

    bcd_digit_collector #(.NDIG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_digit  (in_digit),
        .in_err    (in_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .out_value (out_value),
        .out_valid (out_valid),
        .out_err   (out_err),
        .out_ready (out_ready),
`ifdef BCD_COLLECT_BIN_EN
        .out_bin   (out_bin),
`endif
        .digit_cnt (digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_run++;
        if (got !== exp) begin
            checks_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] d, input logic e);
        in_digit = d;
        in_err   = e;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_err   = 1'b0;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_err"},   32'(out_err),   32'd0);
        check({tag, "_cnt"},   32'(digit_cnt), 32'd0);
        check({tag, "_value"}, 32'(out_value), 32'h0);
        check({tag, "_rdy"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_err = 1'b0;
        in_digit = 4'd0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_empty("reset");

        // Back-to-back 1,2,3,4 with out_ready held high.
        out_ready = 1'b1;
        put(4'd1, 1'b0);
        put(4'd2, 1'b0);
        put(4'd3, 1'b0);
        check("w1234_cnt3", 32'(digit_cnt), 32'd3);
        check("w1234_rdy3", 32'(in_ready), 32'd1);
        check("w1234_nov3", 32'(out_valid), 32'd0);
        put(4'd4, 1'b0);
        check("w1234_valid", 32'(out_valid), 32'd1);
        check("w1234_value", 32'(out_value), 32'h1234);
        check("w1234_err",   32'(out_err),   32'd0);
        check("w1234_rdy",   32'(in_ready),  32'd0);
        check("w1234_cnt",   32'(digit_cnt), 32'd4);
        step();
        check_empty("w1234_after");
        out_ready = 1'b0;

        // Digit above 9 terminates the word with an error.
        put(4'd9, 1'b0);
        put(4'd0, 1'b0);
        put(4'hC, 1'b0);
        check("bad_c_valid", 32'(out_valid), 32'd1);
        check("bad_c_err",   32'(out_err),   32'd1);
        check("bad_c_value", 32'(out_value), 32'h0090);
        check("bad_c_cnt",   32'(digit_cnt), 32'd2);
        check("bad_c_rdy",   32'(in_ready),  32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_empty("bad_c_after");

        // Upstream in_err flag on a legal-looking digit.
        put(4'd5, 1'b0);
        put(4'd6, 1'b0);
        put(4'd3, 1'b1);
        check("inerr_err",   32'(out_err),   32'd1);
        check("inerr_value", 32'(out_value), 32'h0056);
        step();
        check("inerr_hold",  32'(out_value), 32'h0056);
        check("inerr_holdv", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_empty("inerr_after");

        // Full word held under backpressure while upstream keeps offering digits.
        put(4'd8, 1'b0);
        put(4'd7, 1'b0);
        put(4'd6, 1'b0);
        put(4'd5, 1'b0);
        in_digit = 4'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rdy",   32'(in_ready),  32'd0);
            check("bp_value", 32'(out_value), 32'h8765);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_cnt",   32'(digit_cnt), 32'd4);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        // The digit offered in the handshake cycle must not have been taken.
        check_empty("bp_after");
        step();
        check("bp_once", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Idle inputs leave a partial word unchanged.
        put(4'd3, 1'b0);
        step();
        step();
        check("hold_cnt",   32'(digit_cnt), 32'd1);
        check("hold_value", 32'(out_value), 32'h0003);

        // Clear with a digit offered: digit dropped, word emptied.
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_empty("clr_partial");
        put(4'd4, 1'b0);
        put(4'd4, 1'b0);
        clear = 1'b1;
        in_valid = 1'b1;
        in_digit = 4'd1;
        step();
        clear = 1'b0;
        in_valid = 1'b0;
        check_empty("clr_44");

        // Clear beats the output handshake: word not delivered.
        put(4'd1, 1'b0);
        put(4'd2, 1'b0);
        put(4'd3, 1'b0);
        put(4'd4, 1'b0);
        clear = 1'b1;
        out_ready = 1'b1;
        step();
        clear = 1'b0;
        out_ready = 1'b0;
        check_empty("clr_full");

        // Reset mid-word discards the collected digits.
        put(4'd4, 1'b0);
        put(4'd4, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_digit = 4'd1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check_empty("rst_44");

        // All-nines word.
        put(4'd9, 1'b0);
        put(4'd9, 1'b0);
        put(4'd9, 1'b0);
        put(4'd9, 1'b0);
        check("w9999_value", 32'(out_value), 32'h9999);
        check("w9999_valid", 32'(out_valid), 32'd1);
`ifdef BCD_COLLECT_BIN_EN
        check("w9999_bin",   32'(out_bin),   32'd9999);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_empty("w9999_after");
`ifdef BCD_COLLECT_BIN_EN
        check("w9999_bin0", 32'(out_bin), 32'd0);
`endif

        $display("%0d/%0d checks passed", checks_run - checks_fail, checks_run);
        $finish;
    end

endmodule

// File: doc/bcd_digit_collector.md
BCD_DIGIT_COLLECTOR -- requirements
Module: bcd_digit_collector

Interface
REQ-001 Parameter NDIG, default 4, number of BCD digits per word (legal 1..4).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-004 in_digit  input  4  BCD digit from the upstream code-converter stage.
REQ-005 in_err  input  1  upstream invalid-code flag; 1 = digit is not a legal code.
REQ-006 in_valid  input  1  in_digit/in_err present this cycle.
REQ-007 in_ready  output  1  block accepts a digit this cycle.
REQ-008 clear  input  1  synchronous abort of the word in progress.
REQ-009 out_value  output  4*NDIG  packed BCD word; first accepted digit in the most-significant nibble.
REQ-010 out_valid  output  1  word (or error report) available.
REQ-011 out_err  output  1  qualifies out_valid: word terminated by an invalid digit.
REQ-012 out_ready  input  1  downstream consumes the word.
REQ-013 digit_cnt  output  3  digits accepted in the current word (0..NDIG).

Function
REQ-014 States: IDLE (digit_cnt=0), COLLECT (0<digit_cnt<NDIG), FULL, ERR.
REQ-015 in_ready = 1 in IDLE and COLLECT; 0 in FULL and ERR.
REQ-016 A digit is accepted only when in_valid=1 and in_ready=1 on the same edge.
REQ-017 Accepted digit is bad if in_err=1 or in_digit>9; otherwise it is good.
REQ-018 Good digit: out_value <= {out_value[4*NDIG-5:0], in_digit}; digit_cnt increments.
REQ-019 Good digit with digit_cnt=NDIG-1: go to FULL; out_valid=1, out_err=0 from the next cycle (1-cycle latency).
REQ-020 Bad digit: out_value and digit_cnt unchanged; go to ERR; out_valid=1, out_err=1 from the next cycle.
REQ-021 FULL/ERR: out_value, out_err, digit_cnt held stable while out_valid=1 and out_ready=0.
REQ-022 out_valid=1 and out_ready=1: next cycle IDLE; out_value=0, digit_cnt=0, out_valid=0, out_err=0.
REQ-023 Because in_ready=0 in FULL/ERR, no digit is ever accepted in the handshake cycle; in_valid there is ignored, not queued.
REQ-024 clear=1: next cycle IDLE with all outputs at reset values; clear overrides acceptance and handshake in the same cycle (digit dropped, word not delivered).
REQ-025 out_ready ignored when out_valid=0; in_valid=0 leaves all state unchanged.

Reset
REQ-026 rst=1 on an edge: state IDLE, out_value=0, digit_cnt=0, out_valid=0, out_err=0; in_ready=1 from the first cycle after reset.
REQ-027 rst has priority over clear, in_valid and out_ready; reset mid-word discards collected digits.

Configuration
REQ-028 Macro BCD_COLLECT_BIN_EN defined: adds output out_bin (14 bits), updated on each good digit as out_bin <= out_bin*10 + in_digit, reset/cleared/consumed to 0 with out_value, held in FULL/ERR.
REQ-029 Macro BCD_COLLECT_BIN_EN undefined: port out_bin and its logic are absent; all other behaviour identical.

Verification
REQ-030 NDIG=4, digits 1,2,3,4 back-to-back, out_ready=1 -> out_valid=1 one cycle after 4th accept, out_value=16'h1234, out_err=0, IDLE next cycle.
REQ-031 Digits 9,0 then in_digit=4'hC -> out_valid=1, out_err=1, out_value=16'h0090, digit_cnt=2, in_ready=0.
REQ-032 Digits 5,6 then in_err=1 with in_digit=3 -> ERR, out_value=16'h0056; out_ready=1 -> IDLE, out_value=0.
REQ-033 Word 8,7,6,5 complete, out_ready=0 for 5 cycles with in_valid=1, in_digit=2 -> in_ready=0, out_value stays 16'h8765; out_ready=1 -> delivered once.
REQ-034 Digits 4,4 then clear=1 together with in_valid=1, in_digit=1 -> IDLE, digit_cnt=0, out_value=0, no out_valid pulse; rst=1 after two digits -> same result.
REQ-035 With BCD_COLLECT_BIN_EN, digits 9,9,9,9 -> out_value=16'h9999, out_bin=9999.
